// File: rtl/prog_iface_master.sv
// Host-side initiator for the GrainFlex serial configuration chain: turns a byte
// stream into reset/clock/enable/data pins and optionally returns the old chain contents.
module prog_iface_master #(
   parameter int CHAIN_LEN = 512,
   parameter int CLK_DIV   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_start,
   input  logic       cmd_capture,
   output logic       busy,
   output logic       done,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   output logic       s_ready,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       prog_clk,
   output logic       prog_rst,
   output logic       prog_en,
   output logic       prog_din,
   input  logic       prog_dout
);

   localparam int CW    = $clog2(CHAIN_LEN + 1);
   localparam int DW    = $clog2(CLK_DIV);
   localparam int REM   = CHAIN_LEN % 8;
   localparam int ALIGN = (REM == 0) ? 0 : 8 - REM;
   localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PRST     = 3'd1;
   localparam logic [2:0] S_LOAD     = 3'd2;
   localparam logic [2:0] S_SHIFT_LO = 3'd3;
   localparam logic [2:0] S_SHIFT_HI = 3'd4;
   localparam logic [2:0] S_FLUSH    = 3'd5;
   localparam logic [2:0] S_DONE     = 3'd6;

   logic [2:0]    state;
   logic [DW-1:0] div_cnt;
   logic [1:0]    prst_ph;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    byte_bit;
   logic [6:0]    shreg;
   logic [6:0]    cap_reg;
   logic          cap_en;
   logic          dout_meta;
   logic          dout_s;
   logic          div_end;
   logic [7:0]    cap_next;

   assign div_end  = (div_cnt == DIV_LAST);
   assign cap_next = {dout_s, cap_reg};
   // A pending readback byte blocks the next input byte, which stretches prog_clk low.
   assign s_ready  = (state == S_LOAD) && !(cap_en && m_valid);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout_meta <= 1'b0;
         dout_s    <= 1'b0;
      end else begin
         dout_meta <= prog_dout;
         dout_s    <= dout_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         div_cnt  <= '0;
         prst_ph  <= '0;
         bit_cnt  <= '0;
         byte_bit <= '0;
         shreg    <= '0;
         cap_reg  <= '0;
         cap_en   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         m_data   <= '0;
         m_valid  <= 1'b0;
         prog_clk <= 1'b0;
         prog_rst <= 1'b0;
         prog_en  <= 1'b0;
         prog_din <= 1'b0;
      end else begin
         done <= 1'b0;
         if (m_valid && m_ready)
            m_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_start) begin
                  busy     <= 1'b1;
                  cap_en   <= cmd_capture;
                  prog_rst <= 1'b1;
                  prog_clk <= 1'b0;
                  div_cnt  <= '0;
                  prst_ph  <= '0;
                  bit_cnt  <= '0;
                  byte_bit <= '0;
                  state    <= S_PRST;
               end
            end
            S_PRST: begin
               if (div_end) begin
                  div_cnt <= '0;
                  if (prst_ph == 2'd3) begin
                     prog_rst <= 1'b0;
                     prog_clk <= 1'b0;
                     state    <= S_LOAD;
                  end else begin
                     prst_ph  <= prst_ph + 1'b1;
                     prog_clk <= ~prog_clk;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            S_LOAD: begin
               if (s_valid && s_ready) begin
                  shreg    <= s_data[7:1];
                  prog_din <= s_data[0];
                  prog_en  <= 1'b1;
                  div_cnt  <= '0;
                  state    <= S_SHIFT_LO;
               end
            end
            S_SHIFT_LO: begin
               if (div_end) begin
                  div_cnt  <= '0;
                  prog_clk <= 1'b1;
                  state    <= S_SHIFT_HI;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            S_SHIFT_HI: begin
               if (div_end) begin
                  div_cnt  <= '0;
                  prog_clk <= 1'b0;
                  bit_cnt  <= bit_cnt + 1'b1;
                  byte_bit <= byte_bit + 1'b1;
                  if (cap_en)
                     cap_reg <= cap_next[7:1];
                  if (bit_cnt == LAST_BIT) begin
                     prog_en  <= 1'b0;
                     prog_din <= 1'b0;
                     state    <= S_FLUSH;
                     if (cap_en) begin
                        // Short final byte: newest bits sit at the top, move them down to bit 0.
                        m_data  <= cap_next >> ALIGN;
                        m_valid <= 1'b1;
                     end
                  end else if (byte_bit == 3'd7) begin
                     state <= S_LOAD;
                     if (cap_en) begin
                        m_data  <= cap_next;
                        m_valid <= 1'b1;
                     end
                  end else begin
                     prog_din <= shreg[0];
                     shreg    <= shreg >> 1;
                     state    <= S_SHIFT_LO;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            S_FLUSH: begin
               if (!m_valid) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_iface_master.sv
// Self-checking bench for prog_iface_master: 16-bit and 12-bit chain instances share
// stimulus; a pin-level monitor records edges/bytes and compares against a bit-level model.
module tb_prog_iface_master;

   localparam int CLK_DIV = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       cmd_start;
   logic       cmd_capture;
   logic       sel;
   logic [7:0] s_data;
   logic       s_valid;
   logic       m_ready;
   logic       start16;
   logic       start12;
   logic       prog_dout;

   logic       busy16, done16, s_ready16, m_valid16, pclk16, prst16, pen16, pdin16;
   logic [7:0] m_data16;
   logic       busy12, done12, s_ready12, m_valid12, pclk12, prst12, pen12, pdin12;
   logic [7:0] m_data12;

   assign start16 = cmd_start & ~sel;
   assign start12 = cmd_start & sel;

   prog_iface_master #(.CHAIN_LEN(16), .CLK_DIV(CLK_DIV)) dut16 (
      .clk(clk), .reset(reset), .cmd_start(start16), .cmd_capture(cmd_capture),
      .busy(busy16), .done(done16), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready16),
      .m_data(m_data16), .m_valid(m_valid16), .m_ready(m_ready),
      .prog_clk(pclk16), .prog_rst(prst16), .prog_en(pen16), .prog_din(pdin16),
      .prog_dout(prog_dout));

   prog_iface_master #(.CHAIN_LEN(12), .CLK_DIV(CLK_DIV)) dut12 (
      .clk(clk), .reset(reset), .cmd_start(start12), .cmd_capture(cmd_capture),
      .busy(busy12), .done(done12), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready12),
      .m_data(m_data12), .m_valid(m_valid12), .m_ready(m_ready),
      .prog_clk(pclk12), .prog_rst(prst12), .prog_en(pen12), .prog_din(pdin12),
      .prog_dout(prog_dout));

   // Outputs of the instance under test, packed so reset checks cover every pin at once.
   logic [15:0] o16, o12, ao;
   logic        a_busy, a_done, a_s_ready, a_m_valid, a_prog_clk, a_prog_rst, a_prog_en, a_prog_din;
   logic [7:0]  a_m_data;
   assign o16 = {busy16, done16, s_ready16, m_valid16, m_data16, pclk16, prst16, pen16, pdin16};
   assign o12 = {busy12, done12, s_ready12, m_valid12, m_data12, pclk12, prst12, pen12, pdin12};
   assign ao  = sel ? o12 : o16;
   assign a_busy     = ao[15];
   assign a_done     = ao[14];
   assign a_s_ready  = ao[13];
   assign a_m_valid  = ao[12];
   assign a_m_data   = ao[11:4];
   assign a_prog_clk = ao[3];
   assign a_prog_rst = ao[2];
   assign a_prog_en  = ao[1];
   assign a_prog_din = ao[0];

   // Fabric chain model: old contents leave LSB first, advancing on each enabled falling edge.
   logic [63:0] old_bits;
   int          fall_cnt = 0;
   int          fall_base;
   logic [5:0]  dout_idx;
   assign dout_idx  = 6'(fall_cnt - fall_base);
   assign prog_dout = old_bits[dout_idx];

   logic       din_q[$];
   logic [7:0] m_q[$];
   int   en_edges = 0, prst_pulses = 0, rst_cyc = 0, done_cnt = 0;
   int   byte_cnt = 0, mv_cyc = 0, ld_hi = 0;
   logic s_take = 1'b0, m_take = 1'b0;

   always @(posedge a_prog_clk) begin
      if (a_prog_en) begin
         din_q.push_back(a_prog_din);
         en_edges++;
      end
      if (a_prog_rst) prst_pulses++;
   end

   always @(negedge a_prog_clk) if (a_prog_en) fall_cnt++;

   always @(negedge clk) begin
      s_take = s_valid && a_s_ready;
      m_take = a_m_valid && m_ready;
      if (s_take) byte_cnt++;
      if (m_take) m_q.push_back(a_m_data);
      if (a_done) done_cnt++;
      if (a_prog_rst) rst_cyc++;
      if (a_m_valid) mv_cyc++;
      if (a_s_ready && a_prog_clk) ld_hi++;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [15:0] model_din(input int n, input logic [15:0] data);
      logic [31:0] mask;
      mask = (32'h1 << n) - 32'h1;
      return data & mask[15:0];
   endfunction

   function automatic logic [7:0] model_m(input int n, input logic [15:0] old, input int j);
      int w;
      logic [15:0] v;
      w = n - 8 * j;
      if (w > 8) w = 8;
      v = (old >> (8 * j)) & 16'((32'h1 << w) - 32'h1);
      return v[7:0];
   endfunction

   task automatic run_pass(input string tag, input logic s, input logic cap,
                           input logic [15:0] data, input logic [15:0] old,
                           input int sgap, input int mgap, input int abort_edge,
                           input logic [15:0] exp_din, input logic [7:0] exp_m0,
                           input logic [7:0] exp_m1);
      int n, nb, e_base, p_base, r_base, d_base, b_base, mv_base, ld_base, din_base, m_base;
      logic pass_over;
      logic [15:0] got_din;
      logic [7:0]  got_m0, got_m1;
      n  = s ? 12 : 16;
      nb = (n + 7) / 8;
      sel = s;
      cmd_capture = cap;
      old_bits  = {48'h0, old};
      fall_base = fall_cnt;
      e_base = en_edges; p_base = prst_pulses; r_base = rst_cyc; d_base = done_cnt;
      b_base = byte_cnt; mv_base = mv_cyc; ld_base = ld_hi;
      din_base = din_q.size(); m_base = m_q.size();
      m_ready = 1'b0;
      s_valid = 1'b0;

      @(posedge clk); #1 cmd_start = 1'b1;
      @(posedge clk); #1 cmd_start = 1'b0;
      check({tag, ".busy_after_start"}, 32'(a_busy), 32'd1);

      pass_over = 1'b0;
      fork
         begin
            int pos = 0;
            int gap = 0;
            while (!pass_over) begin
               @(posedge clk); #1;
               if (s_take && s_valid) begin
                  pos++;
                  s_valid = 1'b0;
                  gap = sgap;
               end
               if (gap > 0) gap--;
               else if (pos < nb) begin
                  s_valid = 1'b1;
                  s_data  = data[8*pos +: 8];
               end
            end
            s_valid = 1'b0;
         end
         begin
            int gap = mgap;
            while (!pass_over) begin
               @(posedge clk); #1;
               if (m_take && m_ready) gap = mgap;
               if (gap > 0) begin
                  m_ready = 1'b0;
                  if (a_m_valid) gap--;
               end else begin
                  m_ready = 1'b1;
               end
            end
            m_ready = 1'b0;
         end
         begin
            int cyc = 0;
            while (!pass_over) begin
               @(posedge clk); #1;
               cyc++;
               cmd_start = (cyc == 30);
               if (abort_edge >= 0 && (en_edges - e_base) >= abort_edge) begin
                  check({tag, ".pre_abort_en"}, 32'(a_prog_en), 32'd1);
                  cmd_start = 1'b0;
                  #2 reset = 1'b1;
                  #1;
                  check({tag, ".abort_outputs"}, 32'(ao), 32'd0);
                  repeat (3) @(posedge clk);
                  #1 reset = 1'b0;
                  pass_over = 1'b1;
               end else if (done_cnt != d_base || cyc > 3000) begin
                  pass_over = 1'b1;
               end
            end
            cmd_start = 1'b0;
         end
      join

      if (abort_edge < 0) begin
         repeat (40) @(posedge clk);
         #1;
         check({tag, ".done_pulses"}, 32'(done_cnt - d_base), 32'd1);
         check({tag, ".busy_idle"}, 32'(a_busy), 32'd0);
         check({tag, ".prst_cycles"}, 32'(rst_cyc - r_base), 32'(4 * CLK_DIV));
         check({tag, ".prst_pulses"}, 32'(prst_pulses - p_base), 32'd2);
         check({tag, ".en_edges"}, 32'(en_edges - e_base), 32'(n));
         check({tag, ".bytes_in"}, 32'(byte_cnt - b_base), 32'(nb));
         check({tag, ".clk_high_in_stall"}, 32'(ld_hi - ld_base), 32'd0);
         got_din = '0;
         for (int i = 0; i < 16; i++)
            if (din_base + i < din_q.size()) got_din[i] = din_q[din_base + i];
         check({tag, ".din_bits"}, 32'(got_din), 32'(exp_din));
         if (cap) begin
            check({tag, ".bytes_out"}, 32'(m_q.size() - m_base), 32'(nb));
            got_m0 = (m_q.size() > m_base)     ? m_q[m_base]     : 8'hxx;
            got_m1 = (m_q.size() > m_base + 1) ? m_q[m_base + 1] : 8'hxx;
            check({tag, ".m0"}, 32'(got_m0), 32'(exp_m0));
            check({tag, ".m1"}, 32'(got_m1), 32'(exp_m1));
         end else begin
            check({tag, ".m_valid_cycles"}, 32'(mv_cyc - mv_base), 32'd0);
         end
      end
   endtask

   typedef struct {
      logic        sel;
      logic        cap;
      logic [15:0] data;
      logic [15:0] old;
      int          sgap;
      int          mgap;
      logic [15:0] exp_din;
      logic [7:0]  exp_m0;
      logic [7:0]  exp_m1;
   } vec_t;

   vec_t tbl[4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic        rs, rc;
      logic [15:0] rd, ro;
      int          rn;
      tbl[0] = '{1'b0, 1'b0, 16'h3CA5, 16'h0000,  0,  0, 16'h3CA5, 8'h00, 8'h00};
      tbl[1] = '{1'b0, 1'b1, 16'h3CA5, 16'hBEEF,  0,  0, 16'h3CA5, 8'hEF, 8'hBE};
      tbl[2] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF,  0,  0, 16'h0FFF, 8'hFF, 8'h0F};
      tbl[3] = '{1'b0, 1'b1, 16'h3CA5, 16'h1234, 20, 15, 16'h3CA5, 8'h34, 8'h12};

      reset = 1'b1; cmd_start = 1'b0; cmd_capture = 1'b0; sel = 1'b0;
      s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
      old_bits = '0; fall_base = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs16", 32'(o16), 32'd0);
      check("reset_outputs12", 32'(o12), 32'd0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle_outputs16", 32'(o16), 32'd0);

      for (int i = 0; i < 4; i++)
         run_pass($sformatf("vec%0d", i), tbl[i].sel, tbl[i].cap, tbl[i].data, tbl[i].old,
                  tbl[i].sgap, tbl[i].mgap, -1, tbl[i].exp_din, tbl[i].exp_m0, tbl[i].exp_m1);

      run_pass("abort", 1'b0, 1'b1, 16'h5A96, 16'hC3C3, 0, 0, 5, 16'h0, 8'h0, 8'h0);
      repeat (5) @(posedge clk);
      #1;
      check("abort.idle_busy", 32'(a_busy), 32'd0);
      run_pass("after_abort", 1'b0, 1'b1, 16'h3CA5, 16'hBEEF, 0, 0, -1,
               16'h3CA5, 8'hEF, 8'hBE);

      for (int k = 0; k < 10; k++) begin
         rs = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         rd = 16'($urandom);
         ro = 16'($urandom);
         rn = rs ? 12 : 16;
         run_pass($sformatf("rand%0d", k), rs, rc, rd, ro,
                  int'($urandom_range(0, 8)), int'($urandom_range(0, 8)), -1,
                  model_din(rn, rd), model_m(rn, ro, 0), model_m(rn, ro, 1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_iface_master.md
Name: prog_iface_master

Overview:
- Host-side initiator for the GrainFlex fabric's serial configuration interface (progClk / progRst / progEn / progDataIn / progDataOut).
- Takes a configuration bitstream as a byte stream (valid/ready) and generates the reset pulse, gated programming clock, enable and serial data for the fabric.
- Optionally captures the old chain contents shifted out on progDataOut and returns them as a byte stream for readback/verify.
- Sits in the host/test-harness SoC and drives the fabric's ui_in[3:0] pins, reading uo_out[0].

Parameters:
- CHAIN_LEN, 512: total configuration chain length in bits (≥1).
- CLK_DIV, 3: clk cycles per prog_clk half-period (≥3, required by the prog_dout synchronizer).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_start  in  1  start a programming pass (sampled in IDLE only).
- cmd_capture  in  1  latched with cmd_start; 1 = return shifted-out bits on m_*.
- busy  out  1  high from start acceptance until DONE completes.
- done  out  1  one-cycle pulse at end of pass.
- s_data  in  8  bitstream byte, LSB shifted first, byte 0 first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  byte accepted when s_valid & s_ready.
- m_data  out  8  readback byte, first-captured bit in LSB.
- m_valid  out  1  readback byte valid; held until m_ready.
- m_ready  in  1  sink ready.
- prog_clk  out  1  programming clock to fabric (progClk).
- prog_rst  out  1  programming reset to fabric (progRst).
- prog_en  out  1  shift enable to fabric (progEn).
- prog_din  out  1  serial data to fabric (progDataIn).
- prog_dout  in  1  serial data from fabric (progDataOut); asynchronous, 2-flop synchronized internally.

Behaviour:
- Reset values: busy=0, done=0, s_ready=0, m_valid=0, m_data=0, prog_clk=0, prog_rst=0, prog_en=0, prog_din=0; FSM=IDLE; counters=0.
- Reset asserted mid-pass aborts immediately. All pins return to reset values asynchronously; no partial byte is emitted.
- FSM: IDLE -> PRST -> LOAD -> SHIFT_LO -> SHIFT_HI -> (LOAD | SHIFT_LO | FLUSH) -> DONE -> IDLE.
- IDLE:
  - cmd_start=1 sets busy=1 the next cycle and latches cmd_capture.
  - cmd_start is ignored while busy.
- PRST:
  - prog_rst=1 and prog_en=0 while prog_clk toggles for 2 full periods (4*CLK_DIV cycles, starting low).
  - Then prog_rst=0, prog_clk=0.
- LOAD:
  - s_ready=1 until s_valid; the byte is loaded into the shift register on the handshake cycle.
  - While waiting, prog_clk is held low (clock stretched) and prog_en stays at its current value.
- SHIFT_LO:
  - prog_en=1; prog_din = current bit, driven on the first cycle of the low phase.
  - prog_clk low for CLK_DIV cycles.
- SHIFT_HI:
  - prog_clk high for CLK_DIV cycles; the fabric samples prog_din on the rising edge.
  - On the last high cycle, if capturing, the synchronized prog_dout is shifted into the capture register MSB and the register shifts right.
  - Bit counter increments on the falling edge.
- After 8 bits, or after bit CHAIN_LEN-1, control goes to LOAD (more bits remain) or FLUSH (chain complete).
- Capture back-pressure:
  - A full capture byte must be presented on m_* before shifting continues.
  - If m_valid is still high (not yet taken), prog_clk stays low until m_ready.
- Partial last byte when CHAIN_LEN mod 8 ≠ 0:
  - Unused high bits of the final s_data byte are ignored.
  - Readback byte is right-aligned (first captured bit in bit 0) with zero upper bits.
- FLUSH:
  - prog_en=0, prog_din=0.
  - If capturing, the final m_valid byte is emitted and waits for m_ready.
- DONE: done=1 for one cycle, busy=0 on the following cycle, return to IDLE.
- Counts:
  - Exactly CHAIN_LEN rising edges of prog_clk occur with prog_en=1 per pass.
  - Exactly ceil(CHAIN_LEN/8) s_data bytes are consumed per pass.
  - m_data bytes are produced only when capture=1.
- Counter width: $clog2(CHAIN_LEN+1). No wrap is possible within a pass.

Test Plan:
- CHAIN_LEN=16, CLK_DIV=3, capture=0, bytes 0xA5,0x3C with s_valid always high -> prog_rst high for 12 cycles with 2 prog_clk pulses; 16 rising edges with prog_en=1; prog_din at rising edges 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; done pulse; m_valid never asserted.
- Same config, capture=1, prog_dout model = 16-bit shift register preloaded 0xBEEF (LSB out first) -> m_data 0xEF then 0xBE.
- CHAIN_LEN=12, capture=1, bytes 0xFF,0xFF, prog_dout tied 1 -> exactly 12 enabled edges; bits 4–7 of byte 1 unused; m_data 0xFF then 0x0F.
- s_valid low for 20 cycles before byte 1, and m_ready low for 15 cycles -> prog_clk held low with no extra edges during each stall; final bit stream unchanged.
- Assert reset during bit 5 -> all outputs 0 within the reset cycle; a new cmd_start after release performs a full PRST and a complete pass.
- cmd_start pulsed while busy -> ignored; exactly one done pulse.
